// File: rtl/stream_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stream_mux_pkg
//  Purpose  : Shared constants and helpers for the stream multiplexer.
//             - MODE_* encodings for the selection policy
//             - onehot_to_idx(): one-hot vector to binary index (N <= 64)
//  Revision : 1.0  initial release
// ============================================================================
package stream_mux_pkg;

  localparam int MODE_SEL  = 0;  // external select
  localparam int MODE_PRIO = 1;  // fixed priority, lowest index wins
  localparam int MODE_RR   = 2;  // round-robin

  localparam int MAX_CHANNELS = 64;

  // OR-reduction encoder: correct for any one-hot or all-zero input.
  function automatic logic [5:0] onehot_to_idx(input logic [MAX_CHANNELS-1:0] oh);
    logic [5:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_CHANNELS; i++) begin
      if (oh[i]) idx = idx | 6'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_mux_n_arb.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Rotating-priority arbiter. Grants the first requester at or
//             above ptr, wrapping to index 0. With ptr tied to 0 it is a
//             plain lowest-index-wins priority encoder.
//  Ports    : req     [N]      request vector
//             ptr     [SEL_W]  index with highest priority this cycle
//             en      1        grant enable; gnt is zero when low
//             gnt     [N]      one-hot grant (or zero)
//             gnt_idx [SEL_W]  binary index of gnt (0 when no grant)
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] gnt_idx
);

  // Two copies of the request vector side by side. Requests below ptr are
  // masked in the lower copy only, so a lowest-set-bit search over the whole
  // 2N vector finds the first requester at/after ptr, and falls through to
  // the unmasked upper copy to provide the wrap-around.
  logic [2*N-1:0] w_dreq;
  logic [2*N-1:0] w_dgnt;
  logic           w_found;
  logic [N-1:0]   w_gnt;

  always_comb begin
    w_dreq  = {req, req};
    w_dgnt  = '0;
    w_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i < int'(ptr)) w_dreq[i] = 1'b0;
    end
    for (int i = 0; i < 2 * N; i++) begin
      if (!w_found && w_dreq[i]) begin
        w_dgnt[i] = 1'b1;
        w_found   = 1'b1;
      end
    end
  end

  // Fold the two halves back onto N channels; only one bit is ever set.
  assign w_gnt   = en ? (w_dgnt[N-1:0] | w_dgnt[2*N-1:N]) : '0;
  assign gnt     = w_gnt;
  assign gnt_idx = SEL_W'(onehot_to_idx(MAX_CHANNELS'(w_gnt)));

endmodule
`default_nettype wire

// File: rtl/stream_mux_n.sv
`default_nettype none
// ============================================================================
//  Module   : stream_mux_n
//  Purpose  : N-input registered stream multiplexer with valid/ready
//             handshake. One channel is granted per cycle (external select,
//             fixed priority or round-robin) and loaded into a single output
//             register feeding the downstream consumer.
//  Ports    : clk, rst            clock, synchronous active-high reset
//             in_valid  [N]       per-channel request
//             in_data   [N*WIDTH] channel i at [i*WIDTH +: WIDTH]
//             in_ready  [N]       one-hot/zero: channel beat taken this cycle
//             sel       [SEL_W]   channel select (MODE 0 only)
//             out_valid           output register holds a beat
//             out_data  [WIDTH]   registered data
//             out_chan  [SEL_W]   channel that supplied out_data
//             out_ready           downstream accepts the beat
//  Revision : 1.0  initial release
// ============================================================================
module stream_mux_n
  import stream_mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int MODE  = 2,
  parameter int SEL_W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  input  logic [SEL_W-1:0]     sel,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_chan,
  input  logic                 out_ready
);

  logic                 out_valid_q;
  logic [WIDTH-1:0]     out_data_q;
  logic [SEL_W-1:0]     out_chan_q;
  logic [SEL_W-1:0]     rr_ptr_q;
  logic [SEL_W-1:0]     rr_ptr_d;

  logic                 w_load;
  logic [N-1:0]         w_grant;
  logic [SEL_W-1:0]     w_idx;
  logic [WIDTH-1:0]     w_data;
  logic                 w_any;

  // The output register can take a new beat whenever it is empty or its
  // current beat leaves this cycle.
  assign w_load = ~out_valid_q | out_ready;

  generate
    if (MODE == MODE_SEL) begin : g_sel
      // Comparing against every index naturally yields no grant for sel >= N.
      always_comb begin
        w_grant = '0;
        for (int i = 0; i < N; i++) begin
          w_grant[i] = in_valid[i] && (int'(sel) == i);
        end
      end
      assign w_idx = sel;
      logic w_ptr_unused;
      assign w_ptr_unused = ^rr_ptr_q;
    end else if (MODE == MODE_PRIO) begin : g_prio
      rr_arbiter #(.N(N), .SEL_W(SEL_W)) u_arb (
        .req     (in_valid),
        .ptr     ('0),
        .en      (1'b1),
        .gnt     (w_grant),
        .gnt_idx (w_idx)
      );
      logic w_sel_unused;
      assign w_sel_unused = ^{sel, rr_ptr_q};
    end else begin : g_rr
      rr_arbiter #(.N(N), .SEL_W(SEL_W)) u_arb (
        .req     (in_valid),
        .ptr     (rr_ptr_q),
        .en      (1'b1),
        .gnt     (w_grant),
        .gnt_idx (w_idx)
      );
      logic w_sel_unused;
      assign w_sel_unused = ^sel;
    end
  endgenerate

  assign w_any = |w_grant;

  // AND-OR data mux driven by the one-hot grant.
  always_comb begin
    w_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant[i]) w_data = w_data | in_data[i*WIDTH +: WIDTH];
    end
  end

  // Pointer moves just past the channel that was served.
  assign rr_ptr_d = (w_idx == SEL_W'(N - 1)) ? '0 : w_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      rr_ptr_q    <= '0;
    end else if (w_load) begin
      out_valid_q <= w_any;
      if (w_any) begin
        out_data_q <= w_data;
        out_chan_q <= w_idx;
        rr_ptr_q   <= rr_ptr_d;
      end
    end
  end

  assign in_ready  = w_grant & {N{w_load & ~rst}};
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_mux_n
//  Purpose  : Self-checking bench for stream_mux_n. Three instances (MODE 0,
//             1, 2) share clock, reset, data and select. Expected beats are
//             queued per instance by the stimulus; a monitor pops and
//             compares each beat as it leaves the output register.
//  Revision : 1.0  initial release
// ============================================================================
module tb_stream_mux_n;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic [1:0]  sel;

  logic [3:0]  iv   [3];
  logic [3:0]  ir   [3];
  logic        ov   [3];
  logic        ordy [3];
  logic [7:0]  od   [3];
  logic [1:0]  oc   [3];

  int checks;
  int failures;

  logic [9:0] q0[$];
  logic [9:0] q1[$];
  logic [9:0] q2[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  stream_mux_n #(.WIDTH(8), .N(4), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_data(in_data), .in_ready(ir[0]),
    .sel(sel), .out_valid(ov[0]), .out_data(od[0]), .out_chan(oc[0]), .out_ready(ordy[0])
  );
  stream_mux_n #(.WIDTH(8), .N(4), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_data(in_data), .in_ready(ir[1]),
    .sel(sel), .out_valid(ov[1]), .out_data(od[1]), .out_chan(oc[1]), .out_ready(ordy[1])
  );
  stream_mux_n #(.WIDTH(8), .N(4), .MODE(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_data(in_data), .in_ready(ir[2]),
    .sel(sel), .out_valid(ov[2]), .out_data(od[2]), .out_chan(oc[2]), .out_ready(ordy[2])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected beat packing: {chan[1:0], data[7:0]}
  task automatic pop_chk(input int m);
    logic [9:0] e;
    logic       have;
    e    = '0;
    have = 1'b0;
    case (m)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      checks++;
      failures++;
      $display("FAIL beat_unexpected dut%0d actual=%0h required=none", m, {oc[m], od[m]});
    end else begin
      chk($sformatf("beat_dut%0d", m), 32'({oc[m], od[m]}), 32'(e));
    end
  endtask

  // Monitor: a beat is consumed at the posedge following a negedge where
  // out_valid & out_ready, so each beat is seen exactly once.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int m = 0; m < 3; m++) begin
          if (ov[m] && ordy[m]) pop_chk(m);
        end
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    sel      = 2'd0;
    in_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int m = 0; m < 3; m++) begin
      iv[m]   = 4'b0000;
      ordy[m] = 1'b1;
    end
    repeat (3) tick();

    for (int m = 0; m < 3; m++) begin
      chk($sformatf("reset_valid_dut%0d", m), 32'(ov[m]), 32'd0);
      chk($sformatf("reset_data_dut%0d", m), 32'(od[m]), 32'd0);
      chk($sformatf("reset_chan_dut%0d", m), 32'(oc[m]), 32'd0);
    end
    rst = 1'b0;

    // ---- Reset mid-stream with a held beat (MODE 2) ----
    iv[2]   = 4'b0001;
    ordy[2] = 1'b0;
    tick();
    chk("rst_preload_valid", 32'(ov[2]), 32'd1);
    chk("rst_preload_data", 32'(od[2]), 32'h11);
    rst     = 1'b1;
    ordy[2] = 1'b1;
    #1;
    chk("rst_in_ready_low", 32'(ir[2]), 32'd0);
    tick();
    chk("rst_in_ready_low2", 32'(ir[2]), 32'd0);
    chk("rst_drop_valid", 32'(ov[2]), 32'd0);
    chk("rst_drop_data", 32'(od[2]), 32'd0);
    chk("rst_drop_chan", 32'(oc[2]), 32'd0);
    rst   = 1'b0;
    iv[2] = 4'b0000;

    // ---- Round-robin, all requesting, no bubbles: 0,1,2,3,0 ----
    q2.push_back({2'd0, 8'h11});
    q2.push_back({2'd1, 8'h22});
    q2.push_back({2'd2, 8'h33});
    q2.push_back({2'd3, 8'h44});
    q2.push_back({2'd0, 8'h11});
    iv[2] = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("rr_no_bubble_%0d", k), 32'(ov[2]), 32'd1);
    end
    iv[2] = 4'b0000;
    tick();
    chk("rr_idle_valid", 32'(ov[2]), 32'd0);

    // ---- Round-robin wrap: ptr 1 -> ch1, ptr 2 with 0011 -> ch0, then ch1 ----
    q2.push_back({2'd1, 8'h22});
    q2.push_back({2'd0, 8'h11});
    q2.push_back({2'd1, 8'h22});
    iv[2] = 4'b0010;
    tick();
    iv[2] = 4'b0011;
    tick();
    tick();
    iv[2] = 4'b0000;
    tick();
    chk("wrap_idle_valid", 32'(ov[2]), 32'd0);

    // ---- Backpressure (MODE 2): hold ch3 beat for 3 stalled cycles ----
    q2.push_back({2'd3, 8'h44});
    iv[2] = 4'b1000;
    tick();
    ordy[2] = 1'b0;
    iv[2]   = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall_in_ready_%0d", k), 32'(ir[2]), 32'd0);
      chk($sformatf("stall_valid_%0d", k), 32'(ov[2]), 32'd1);
      chk($sformatf("stall_data_%0d", k), 32'(od[2]), 32'h44);
      chk($sformatf("stall_chan_%0d", k), 32'(oc[2]), 32'd3);
      tick();
    end
    ordy[2] = 1'b1;
    q2.push_back({2'd0, 8'h11});
    #1;
    chk("release_in_ready", 32'(ir[2]), 32'b0001);
    tick();
    chk("release_valid", 32'(ov[2]), 32'd1);
    chk("release_data", 32'(od[2]), 32'h11);
    iv[2] = 4'b0000;
    tick();

    // ---- Fixed priority (MODE 1): ch1 always wins over ch3 ----
    in_data = {8'h3C, 8'h33, 8'hA5, 8'h11};
    for (int k = 0; k < 4; k++) q1.push_back({2'd1, 8'hA5});
    iv[1] = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("prio_in_ready_%0d", k), 32'(ir[1]), 32'b0010);
      tick();
      chk($sformatf("prio_valid_%0d", k), 32'(ov[1]), 32'd1);
    end
    iv[1] = 4'b0000;
    tick();
    chk("prio_idle_valid", 32'(ov[1]), 32'd0);

    // ---- External select (MODE 0) ----
    in_data = {8'h3C, 8'h7E, 8'hA5, 8'h11};
    sel     = 2'd2;
    iv[0]   = 4'b0100;
    q0.push_back({2'd2, 8'h7E});
    #1;
    chk("sel_in_ready", 32'(ir[0]), 32'b0100);
    tick();
    chk("sel_valid", 32'(ov[0]), 32'd1);
    chk("sel_data", 32'(od[0]), 32'h7E);
    iv[0] = 4'b1011;
    #1;
    chk("sel_unrequested_ready", 32'(ir[0]), 32'd0);
    tick();
    chk("sel_valid_drop", 32'(ov[0]), 32'd0);
    iv[0] = 4'b0000;

    repeat (2) tick();
    chk("sb_empty_dut0", 32'(q0.size()), 32'd0);
    chk("sb_empty_dut1", 32'(q1.size()), 32'd0);
    chk("sb_empty_dut2", 32'(q2.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
